idct8_serial: RTL and testbench
===============================

# idct8_serial

Serial 8-point inverse integer DCT. It accepts one row of eight DCT coefficients over a valid/ready stream and reconstructs eight spatial samples. The samples leave over a second valid/ready stream. It sits on the decode side of the 2D DCT datapath and inverts the forward 8-point transform, which produces unscaled Q17.0 coefficients. Row/column transposition is outside this block.

## Interface
- IN_W, 18: coefficient width, signed.
- OUT_W, 9: sample width, signed (Q8.0).
- SHIFT, 15: final right shift; forward×inverse gain is 64·64·8 = 2^15.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  coefficient present.
- in_ready  out  1  block accepts a coefficient.
- in_coef  in  IN_W  coefficient y[k], signed; k is implied by arrival order 0..7.
- in_last  in  1  marks the coefficient the producer considers k=7.
- out_valid  out  1  sample present.
- out_ready  in  1  consumer accepts a sample.
- out_sample  out  OUT_W  reconstructed sample x[n], signed.
- out_last  out  1  high with x[7].
- frame_err  out  1  sticky framing error; cleared only by rst.

## Operation
- The FSM has three states: LOAD, CALC and DRAIN. Reset enters LOAD with cnt=0.
- Reset values: in_ready=0, out_valid=0, out_sample=0, out_last=0, frame_err=0. The coefficient buffer is cleared to 0.
- LOAD:
  - in_ready=1.
  - On each in_valid&in_ready, store the coefficient in buf[cnt] and increment cnt.
  - When the accept has cnt=7, go to CALC and set cnt=0.
  - frame_err sets if in_last=1 with cnt≠7, or in_last=0 with cnt=7. The framing itself is driven by cnt; in_last never shortens or extends a row.
- CALC: one cycle. Register x[0] into out_sample, set out_valid=1 and out_last=0, then go to DRAIN.
- DRAIN:
  - On out_valid&out_ready with n<7, register x[n+1] and set out_last=(n+1==7).
  - On the handshake with n=7, clear out_valid and out_last and return to LOAD.
  - Without a handshake, out_sample, out_valid and out_last hold stable.
- Inverse matrix: x[n] = Σk M[k][n]·y[k], with these rows of M:
  - k0: 64 ×8
  - k1: 89 75 50 18 −18 −50 −75 −89
  - k2: 83 36 −36 −83 −83 −36 36 83
  - k3: 75 −18 −89 −50 50 89 18 −75
  - k4: 64 −64 −64 64 64 −64 −64 64
  - k5: 50 −89 18 75 −75 −18 89 −50
  - k6: 36 −83 83 −36 −36 83 −83 36
  - k7: 18 −50 75 −89 89 −75 50 −18
- Constant products are built from shifts and adds; no generic multipliers. Results must be bit-exact to the integer formula.
- Arithmetic:
  - Sum in a signed accumulator of at least IN_W+10 = 28 bits. The worst case is |y|≤2^17 × Σ|M|=479, so no overflow is possible.
  - Then r = (sum + 2^(SHIFT−1)) >>> SHIFT: arithmetic shift, round half up.
  - r is reduced to OUT_W according to the Configuration section.
- rst in any state, including mid-LOAD or mid-DRAIN:
  - Discard the buffered row and partial count.
  - Drop out_valid on the next edge.
  - The next accepted coefficient is y[0].

## Timing
- The last coefficient (k=7) is accepted at edge E. The block is in CALC during the following cycle. x[0] is registered at edge E+1, so out_valid is first high in the cycle after E+1.
- With out_ready held high: one sample per cycle, x[0]..x[7] on consecutive cycles.
- in_ready first reasserts in the cycle after the x[7] handshake edge.
- Minimum row period is 17 cycles: 8 in + 1 calc + 8 out. There is no overlap between input and output.
- in_ready is low in CALC and DRAIN. in_valid during those states is ignored and nothing is consumed.

## Configuration
- IDCT8_SAT_EN defined: r is clamped to [−2^(OUT_W−1), 2^(OUT_W−1)−1], which is [−256, 255] by default.
- IDCT8_SAT_EN undefined: out_sample is the low OUT_W bits of r (two's-complement wrap). Clamp logic is omitted.

## Test plan
- DC row: y = {51200, 0×7} → eight samples, all 100. out_last is high only on the 8th. out_valid first rises two cycles after the 8th accept.
- Single AC row: y1 = 32768, all others 0 → 89, 75, 50, 18, −18, −50, −75, −89. This checks sign and rounding (−18 exact, not −17).
- Overrange: y0 = 131071, others 0 → 255 for all samples with IDCT8_SAT_EN. Without it, every sample is −256 (wrap of 256).
- Backpressure: toggle out_ready at random for the DC row → sample sequence unchanged, outputs stable while stalled, in_ready stays low until after x[7].
- Framing: in_last on the 4th coefficient → frame_err=1 and stays high. The row still completes after 8 coefficients. Next row with correct in_last → frame_err still 1.
- Reset mid-DRAIN: assert rst after x[2] is sent → next cycle out_valid=0 and in_ready=0, then LOAD with in_ready=1. A fresh DC row of 100 reproduces eight samples of 100.

Source files
------------

// File: rtl/idct8_serial.sv
// -----------------------------------------------------------------------------
// idct8_serial
//
// Serial 8-point inverse integer DCT. One row of eight signed coefficients
// y[0..7] arrives over a valid/ready stream. Eight reconstructed samples
// x[0..7] are then produced over a second valid/ready stream. Input and output
// never overlap: LOAD (8 accepts) -> CALC (1 cycle) -> DRAIN (8 handshakes).
//
// The constant products are built from shifts and adds, using an even/odd
// butterfly. All eight column sums are available from the buffered row. The
// one needed next is muxed, rounded (half up), shifted right by SHIFT and
// registered.
//
// Build option:
//   IDCT8_SAT_EN  defined   -> result clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//                 undefined -> result wraps to its low OUT_W bits
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   in_valid    coefficient present
//   in_ready    block accepts a coefficient (registered)
//   in_coef     coefficient y[k], signed, k implied by arrival order
//   in_last     producer's end-of-row marker (only checked, never used to frame)
//   out_valid   sample present
//   out_ready   consumer accepts a sample
//   out_sample  reconstructed sample x[n], signed
//   out_last    high with x[7]
//   frame_err   sticky framing error, cleared only by rst
// -----------------------------------------------------------------------------
module idct8_serial #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 9,
    parameter int SHIFT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_coef,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_sample,
    output logic             out_last,
    output logic             frame_err
);

    localparam int ACC_W = IN_W + 10;
    localparam int RND_I = 1 << (SHIFT - 1);
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(RND_I);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CALC  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             frame_err_q, frame_err_d;
    logic [OUT_W-1:0] out_sample_q, out_sample_d;
    logic [IN_W-1:0]  coef_q [8];

    logic             accept;
    logic [2:0]       sel_idx;
    logic signed [ACC_W-1:0] y     [8];
    logic signed [ACC_W-1:0] ev    [4];
    logic signed [ACC_W-1:0] od    [4];
    logic signed [ACC_W-1:0] x_all [8];
    logic signed [ACC_W-1:0] rnd_sum;
    logic [OUT_W-1:0]        sample_next;

    // Constant multipliers as shift/add trees.
    function automatic logic signed [ACC_W-1:0] m18(input logic signed [ACC_W-1:0] v);
        return (v <<< 4) + (v <<< 1);
    endfunction
    function automatic logic signed [ACC_W-1:0] m36(input logic signed [ACC_W-1:0] v);
        return (v <<< 5) + (v <<< 2);
    endfunction
    function automatic logic signed [ACC_W-1:0] m50(input logic signed [ACC_W-1:0] v);
        return (v <<< 5) + (v <<< 4) + (v <<< 1);
    endfunction
    function automatic logic signed [ACC_W-1:0] m64(input logic signed [ACC_W-1:0] v);
        return v <<< 6;
    endfunction
    function automatic logic signed [ACC_W-1:0] m75(input logic signed [ACC_W-1:0] v);
        return (v <<< 6) + (v <<< 3) + (v <<< 1) + v;
    endfunction
    function automatic logic signed [ACC_W-1:0] m83(input logic signed [ACC_W-1:0] v);
        return (v <<< 6) + (v <<< 4) + (v <<< 1) + v;
    endfunction
    function automatic logic signed [ACC_W-1:0] m89(input logic signed [ACC_W-1:0] v);
        return (v <<< 6) + (v <<< 4) + (v <<< 3) + v;
    endfunction

    // in_ready_q is only ever high while in LOAD, so it alone qualifies accepts.
    assign accept = in_valid & in_ready_q;

    // Coefficient buffer; cleared by reset so a discarded row never leaks.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                coef_q[i] <= '0;
            end
        end else if (accept) begin
            coef_q[cnt_q] <= in_coef;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sext
            assign y[gi] = {{(ACC_W - IN_W){coef_q[gi][IN_W-1]}}, coef_q[gi]};
        end
    endgenerate

    // Even part uses y0,y2,y4,y6; odd part uses y1,y3,y5,y7.
    // x[n] = ev[n] + od[n], x[7-n] = ev[n] - od[n] for n = 0..3.
    assign ev[0] = m64(y[0]) + m83(y[2]) + m64(y[4]) + m36(y[6]);
    assign ev[1] = m64(y[0]) + m36(y[2]) - m64(y[4]) - m83(y[6]);
    assign ev[2] = m64(y[0]) - m36(y[2]) - m64(y[4]) + m83(y[6]);
    assign ev[3] = m64(y[0]) - m83(y[2]) + m64(y[4]) - m36(y[6]);

    assign od[0] = m89(y[1]) + m75(y[3]) + m50(y[5]) + m18(y[7]);
    assign od[1] = m75(y[1]) - m18(y[3]) - m89(y[5]) - m50(y[7]);
    assign od[2] = m50(y[1]) - m89(y[3]) + m18(y[5]) + m75(y[7]);
    assign od[3] = m18(y[1]) - m50(y[3]) + m75(y[5]) - m89(y[7]);

    generate
        for (gi = 0; gi < 4; gi++) begin : g_bfly
            assign x_all[gi]     = ev[gi] + od[gi];
            assign x_all[7 - gi] = ev[gi] - od[gi];
        end
    endgenerate

    // CALC emits x[0]; each DRAIN handshake at index n emits x[n+1].
    assign sel_idx = (state_q == CALC) ? 3'd0 : 3'(cnt_q + 3'd1);
    assign rnd_sum = x_all[sel_idx] + RND;

`ifdef IDCT8_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    logic signed [ACC_W-1:0] r_full;
    assign r_full = rnd_sum >>> SHIFT;

    always_comb begin
        sample_next = r_full[OUT_W-1:0];
        if (r_full > SAT_HI) begin
            sample_next = OUT_W'(SAT_HI);
        end else if (r_full < SAT_LO) begin
            sample_next = OUT_W'(SAT_LO);
        end
    end
`else
    assign sample_next = OUT_W'(rnd_sum >>> SHIFT);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_sample_q <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_sample_q <= out_sample_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_sample_d = out_sample_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            LOAD: begin
                if (accept) begin
                    // Row framing is purely count based; in_last is only audited.
                    if (in_last != (cnt_q == 3'd7)) begin
                        frame_err_d = 1'b1;
                    end
                    if (cnt_q == 3'd7) begin
                        state_d = CALC;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            CALC: begin
                out_sample_d = sample_next;
                out_valid_d  = 1'b1;
                out_last_d   = 1'b0;
                cnt_d        = 3'd0;
                state_d      = DRAIN;
            end
            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (cnt_q != 3'd7) begin
                        cnt_d        = cnt_q + 3'd1;
                        out_sample_d = sample_next;
                        out_last_d   = (cnt_q == 3'd6);
                    end else begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        cnt_d       = 3'd0;
                        state_d     = LOAD;
                    end
                end
            end
            default: begin
                state_d = LOAD;
                cnt_d   = 3'd0;
            end
        endcase

        // Registered ready: reasserts the cycle after the x[7] handshake and
        // stays low for the first cycle after reset.
        in_ready_d = (state_d == LOAD);
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_sample = out_sample_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_idct8_serial.sv
// -----------------------------------------------------------------------------
// tb_idct8_serial
//
// Self-checking bench for idct8_serial. It runs a table of hand-computed
// rows, then random rows checked against a matrix-product reference model.
// It finishes with hand-written sequences for backpressure, framing errors
// and reset during DRAIN.
// -----------------------------------------------------------------------------
module tb_idct8_serial;

    localparam int IN_W  = 18;
    localparam int OUT_W = 9;
    localparam int SHIFT = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             out_ready = 1'b0;
    logic [IN_W-1:0]  in_coef = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_last;
    logic             frame_err;
    logic [OUT_W-1:0] out_sample;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    idct8_serial #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .SHIFT(SHIFT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coef   (in_coef),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sample(out_sample),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    // Inverse matrix, M[k][n].
    int MAT [8][8] = '{
        '{64,  64,  64,  64,  64,  64,  64,  64},
        '{89,  75,  50,  18, -18, -50, -75, -89},
        '{83,  36, -36, -83, -83, -36,  36,  83},
        '{75, -18, -89, -50,  50,  89,  18, -75},
        '{64, -64, -64,  64,  64, -64, -64,  64},
        '{50, -89,  18,  75, -75, -18,  89, -50},
        '{36, -83,  83, -36, -36,  83, -83,  36},
        '{18, -50,  75, -89,  89, -75,  50, -18}
    };

    typedef struct {
        int y [8];
        int e [8];
    } vec_t;

    vec_t vecs [7];

    function automatic int ref_sample(input int yy [8], input int n);
        longint s;
        longint r;
        s = 0;
        for (int k = 0; k < 8; k++) begin
            s += longint'(MAT[k][n]) * longint'(yy[k]);
        end
        r = (s + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
`ifdef IDCT8_SAT_EN
        if (r > 255) r = 255;
        if (r < -256) r = -256;
`else
        r = r & 511;
        if (r >= 256) r = r - 512;
`endif
        return int'(r);
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int smp();
        return int'($signed(out_sample));
    endfunction

    // Presents eight coefficients; in_last is raised at position last_idx.
    // Returns at #1 after the edge that accepted the 8th coefficient.
    task automatic send_row(input int yy [8], input int last_idx);
        int guard;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_coef  = IN_W'(yy[i]);
            in_last  = (i == last_idx);
            guard = 0;
            while (!in_ready && guard < 100) begin
                @(posedge clk);
                #1;
                guard++;
            end
            chk(in_ready == 1'b1, "send_ready_timeout", guard, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Collects num samples. Stall stability and in_ready low are checked
    // while draining. With junk set, in_valid is held high throughout.
    task automatic recv_row(input int num, input bit rand_rdy, input bit junk,
                            output int got [8], output bit lst [8], output int cyc);
        int n;
        int guard;
        bit stalled;
        int held_s;
        bit held_l;
        n = 0;
        guard = 0;
        stalled = 1'b0;
        held_s = 0;
        held_l = 1'b0;
        for (int i = 0; i < 8; i++) begin
            got[i] = 0;
            lst[i] = 1'b0;
        end
        if (junk) begin
            in_valid = 1'b1;
            in_coef  = IN_W'(999);
            in_last  = 1'b0;
        end
        while (n < num && guard < 400) begin
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                chk(out_valid && smp() == held_s && out_last == held_l,
                    "stall_hold", smp(), held_s);
            end
            if (out_valid) begin
                chk(in_ready == 1'b0, "in_ready_low_drain", int'(in_ready), 0);
                if (out_ready) begin
                    got[n] = smp();
                    lst[n] = out_last;
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_s = smp();
                    held_l = out_last;
                end
            end
            @(posedge clk);
            #1;
            guard++;
        end
        cyc = guard;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk(n == num, "recv_timeout", n, num);
    endtask

    task automatic cmp_row(input string tag, input int got [8], input bit lst [8],
                           input int exp [8]);
        for (int n = 0; n < 8; n++) begin
            chk(got[n] == exp[n], tag, got[n], exp[n]);
            chk(lst[n] == (n == 7), "out_last", int'(lst[n]), int'(n == 7));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got [8];
        bit lst [8];
        int cyc;
        int ov;
        int yy [8];
        int ex [8];
        int dc [8];
        int dc_e [8];

`ifdef IDCT8_SAT_EN
        ov = 255;
`else
        ov = -256;
`endif
        dc   = '{51200, 0, 0, 0, 0, 0, 0, 0};
        dc_e = '{100, 100, 100, 100, 100, 100, 100, 100};

        vecs[0].y = '{51200, 0, 0, 0, 0, 0, 0, 0};
        vecs[0].e = '{100, 100, 100, 100, 100, 100, 100, 100};
        vecs[1].y = '{0, 32768, 0, 0, 0, 0, 0, 0};
        vecs[1].e = '{89, 75, 50, 18, -18, -50, -75, -89};
        vecs[2].y = '{131071, 0, 0, 0, 0, 0, 0, 0};
        vecs[2].e = '{ov, ov, ov, ov, ov, ov, ov, ov};
        vecs[3].y = '{-51200, 0, 0, 0, 0, 0, 0, 0};
        vecs[3].e = '{-100, -100, -100, -100, -100, -100, -100, -100};
        vecs[4].y = '{0, 0, 32768, 0, 0, 0, 0, 0};
        vecs[4].e = '{83, 36, -36, -83, -83, -36, 36, 83};
        vecs[5].y = '{0, 0, 0, 0, 32768, 0, 0, 0};
        vecs[5].e = '{64, -64, -64, 64, 64, -64, -64, 64};
        vecs[6].y = '{51200, 32768, 0, 0, 0, 0, 0, 0};
        vecs[6].e = '{189, 175, 150, 118, 82, 50, 25, 11};

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk(in_ready == 1'b0, "rst_in_ready", int'(in_ready), 0);
        chk(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
        chk(smp() == 0, "rst_out_sample", smp(), 0);
        chk(out_last == 1'b0, "rst_out_last", int'(out_last), 0);
        chk(frame_err == 1'b0, "rst_frame_err", int'(frame_err), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk(in_ready == 1'b1, "in_ready_after_rst", int'(in_ready), 1);

        // Table-driven rows with out_ready held high.
        for (int v = 0; v < 7; v++) begin
            send_row(vecs[v].y, 7);
            chk(out_valid == 1'b0, "out_valid_calc", int'(out_valid), 0);
            @(posedge clk);
            #1;
            chk(out_valid == 1'b1, "out_valid_rise", int'(out_valid), 1);
            recv_row(8, 1'b0, 1'b0, got, lst, cyc);
            chk(cyc == 8, "drain_cycles", cyc, 8);
            cmp_row("table_sample", got, lst, vecs[v].e);
            chk(in_ready == 1'b1, "in_ready_after_x7", int'(in_ready), 1);
            chk(out_valid == 1'b0, "out_valid_after_x7", int'(out_valid), 0);
            $display("TXN table row=%0d x0=%0d x7=%0d", v, got[0], got[7]);
        end

        // Random rows against the reference model.
        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < 8; k++) begin
                if (r % 3 != 0) begin
                    yy[k] = int'($urandom_range(0, 8191)) - 4096;
                end else begin
                    yy[k] = int'($urandom_range(0, 262143)) - 131072;
                end
            end
            for (int n = 0; n < 8; n++) begin
                ex[n] = ref_sample(yy, n);
            end
            send_row(yy, 7);
            recv_row(8, r[0], 1'b0, got, lst, cyc);
            cmp_row("random_sample", got, lst, ex);
            $display("TXN random row=%0d x0=%0d x7=%0d", r, got[0], got[7]);
        end

        // Backpressure with in_valid held high while draining.
        send_row(dc, 7);
        recv_row(8, 1'b1, 1'b1, got, lst, cyc);
        cmp_row("bp_sample", got, lst, dc_e);
        chk(in_ready == 1'b1, "bp_in_ready_after_x7", int'(in_ready), 1);
        // A row after the junk period must still frame from y[0].
        send_row(vecs[1].y, 7);
        recv_row(8, 1'b0, 1'b0, got, lst, cyc);
        cmp_row("bp_next_row", got, lst, vecs[1].e);
        $display("TXN backpressure x0=%0d x7=%0d", got[0], got[7]);

        // Framing: in_last on the 4th coefficient.
        chk(frame_err == 1'b0, "frame_err_clean", int'(frame_err), 0);
        send_row(dc, 3);
        chk(frame_err == 1'b1, "frame_err_set", int'(frame_err), 1);
        recv_row(8, 1'b0, 1'b0, got, lst, cyc);
        cmp_row("frame_sample", got, lst, dc_e);
        send_row(dc, 7);
        recv_row(8, 1'b0, 1'b0, got, lst, cyc);
        cmp_row("frame_next_sample", got, lst, dc_e);
        chk(frame_err == 1'b1, "frame_err_sticky", int'(frame_err), 1);
        $display("TXN framing frame_err=%0d", frame_err);

        // Reset in the middle of DRAIN, after x[2] has been handshaken.
        send_row(vecs[1].y, 7);
        recv_row(3, 1'b0, 1'b0, got, lst, cyc);
        chk(got[2] == 50, "pre_rst_x2", got[2], 50);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk(out_valid == 1'b0, "mid_rst_out_valid", int'(out_valid), 0);
        chk(in_ready == 1'b0, "mid_rst_in_ready", int'(in_ready), 0);
        chk(frame_err == 1'b0, "mid_rst_frame_err", int'(frame_err), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk(in_ready == 1'b1, "post_rst_in_ready", int'(in_ready), 1);
        chk(out_valid == 1'b0, "post_rst_out_valid", int'(out_valid), 0);
        send_row(dc, 7);
        recv_row(8, 1'b0, 1'b0, got, lst, cyc);
        cmp_row("post_rst_sample", got, lst, dc_e);
        chk(frame_err == 1'b0, "post_rst_frame_err", int'(frame_err), 0);
        $display("TXN reset_mid_drain x0=%0d x7=%0d", got[0], got[7]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
